// File: rtl/lfsr_pkg.sv
// Shared definitions for the 13-bit Fibonacci LFSR generator and its receive-side checker.
package lfsr_pkg;

    localparam int              WIDTH    = 13;
    localparam logic [WIDTH-1:0] TAP_MASK = 13'h100D;

    // Encoding 2'd3 is unused and recovers to ST_SEARCH.
    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] w);
        return {w[WIDTH-2:0], ^(w & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One combinational LFSR advance: o_word = next(i_word).
module lfsr_step
    import lfsr_pkg::*;
(
    input  logic [WIDTH-1:0] i_word,
    output logic [WIDTH-1:0] o_word
);

    assign o_word = lfsr_next(i_word);

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 13-bit LFSR stream: searches, verifies a run of
// correct predictions, then flywheels on its own prediction and counts mismatches.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    state_t           r_state;
    logic             r_locked;
    logic             r_err_pulse;
    logic [ERR_W-1:0] r_err_count;
    logic [WIDTH-1:0] r_expected;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_miss_cnt;

    logic [WIDTH-1:0] w_next_in;
    logic [WIDTH-1:0] w_next_exp;
    logic [3:0]       w_match_inc;
    logic [3:0]       w_miss_inc;
    logic             w_hit;
    logic             w_zero;
    logic [ERR_W-1:0] w_err_base;
    logic [ERR_W-1:0] w_err_inc;

    lfsr_step u_step_in  (.i_word(in_data),    .o_word(w_next_in));
    lfsr_step u_step_exp (.i_word(r_expected), .o_word(w_next_exp));

    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;
    assign w_hit       = (in_data == r_expected);
    assign w_zero      = (in_data == '0);

    // A clear in the same cycle as an error wipes the old count, then the error still counts.
    assign w_err_base = err_clr ? '0 : r_err_count;
    assign w_err_inc  = (&w_err_base) ? w_err_base : w_err_base + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (err_clr)
                r_err_count <= '0;

            case (r_state)
                ST_SEARCH: begin
                    if (in_valid && !w_zero) begin
                        r_expected  <= w_next_in;
                        r_match_cnt <= '0;
                        r_state     <= ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (in_valid) begin
                        if (w_hit) begin
                            r_match_cnt <= w_match_inc;
                            r_expected  <= w_next_in;
                            if (w_match_inc == 4'(LOCK_CNT)) begin
                                r_state    <= ST_LOCKED;
                                r_locked   <= 1'b1;
                                r_miss_cnt <= '0;
                            end
                        end else if (!w_zero) begin
                            r_expected  <= w_next_in;
                            r_match_cnt <= '0;
                        end else begin
                            r_state <= ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the prediction advances from itself, never from the data.
                    if (in_valid) begin
                        r_expected <= w_next_exp;
                        if (w_hit) begin
                            r_miss_cnt <= '0;
                        end else begin
                            r_err_pulse <= 1'b1;
                            r_err_count <= w_err_inc;
                            r_miss_cnt  <= w_miss_inc;
                            if (w_miss_inc == 4'(LOSS_CNT)) begin
                                r_state  <= ST_SEARCH;
                                r_locked <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    r_state  <= ST_SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign expected  = r_expected;

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed test-plan steps plus a randomized generator stream, checked against a reference model.
module tb_lfsr_checker;

    localparam int W  = 13;
    localparam int EW = 5;
    localparam int ERR_MAX = (1 << EW) - 1;

    logic          clock = 1'b0;
    logic          reset, in_valid, err_clr;
    logic [W-1:0]  in_data;
    logic          locked, err_pulse;
    logic [EW-1:0] err_count;
    logic [W-1:0]  expected;

    always #5 clock = ~clock;

    lfsr_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(EW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .expected  (expected)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: mode 0 = searching, 1 = verifying, 2 = locked.
    int           m_mode;
    logic [W-1:0] m_exp;
    int           m_run, m_miss, m_err;
    bit           m_pulse;
    logic [W-1:0] g;

    // Parity of the tapped bits computed by counting, then a doubling shift modulo 2^W.
    function automatic logic [W-1:0] ref_next(input logic [W-1:0] w);
        int taps[4];
        int ones;
        taps = '{12, 3, 2, 0};
        ones = 0;
        for (int k = 0; k < 4; k++) ones += int'(w[taps[k]]);
        return W'((int'(w) * 2 + (ones % 2)) % (1 << W));
    endfunction

    task automatic model_step(input bit v, input logic [W-1:0] d, input bit clr, input bit rst);
        bit err_hit;
        err_hit = 0;
        m_pulse = 0;
        if (rst) begin
            m_mode = 0; m_exp = '0; m_run = 0; m_miss = 0; m_err = 0;
            return;
        end
        if (v) begin
            case (m_mode)
                0: if (d != 0) begin m_exp = ref_next(d); m_run = 0; m_mode = 1; end
                1: begin
                    if (d == m_exp) begin
                        m_run++;
                        m_exp = ref_next(d);
                        if (m_run == 4) begin m_mode = 2; m_miss = 0; end
                    end else if (d != 0) begin
                        m_exp = ref_next(d); m_run = 0;
                    end else begin
                        m_mode = 0;
                    end
                end
                default: begin
                    if (d == m_exp) m_miss = 0;
                    else begin
                        err_hit = 1; m_pulse = 1; m_miss++;
                        if (m_miss == 3) m_mode = 0;
                    end
                    m_exp = ref_next(m_exp);
                end
            endcase
        end
        if (clr) m_err = 0;
        if (err_hit && m_err < ERR_MAX) m_err++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit v, input logic [W-1:0] d, input bit clr = 0, input bit rst = 0);
        reset = rst; in_valid = v; in_data = d; err_clr = clr;
        @(posedge clock);
        model_step(v, d, clr, rst);
        #1;
        check("locked",    32'(locked),    32'(m_mode == 2));
        check("err_pulse", 32'(err_pulse), 32'(m_pulse));
        check("err_count", 32'(err_count), 32'(m_err));
        check("expected",  32'(expected),  32'(m_exp));
        reset = 0; in_valid = 0; err_clr = 0; in_data = '0;
    endtask

    initial begin
        int r;
        reset = 1; in_valid = 0; err_clr = 0; in_data = '0;
        m_mode = 0; m_exp = '0; m_run = 0; m_miss = 0; m_err = 0; m_pulse = 0;

        cyc(0, '0, 0, 1);
        cyc(1, 13'h1FFF, 1, 1);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_expected", 32'(expected), 32'd0);

        // 1: acquire lock on the canonical sequence.
        check("next_000F", 32'(ref_next(13'h000F)), 32'h001F);
        g = 13'h000F;
        repeat (5) begin cyc(1, g); g = ref_next(g); end
        check("t1_locked", 32'(locked), 32'd1);
        check("t1_expected", 32'(expected), 32'h01FF);
        check("t1_errs", 32'(err_count), 32'd0);

        // 2: single corrupt word while locked.
        cyc(1, 13'h01FF);
        cyc(1, 13'h1234);
        check("t2_pulse", 32'(err_pulse), 32'd1);
        cyc(1, 13'h07FF);
        check("t2_pulse_gone", 32'(err_pulse), 32'd0);
        check("t2_errs", 32'(err_count), 32'd1);
        check("t2_locked", 32'(locked), 32'd1);
        check("t2_expected", 32'(expected), 32'h0FFF);

        // 3: three misses in a row drop lock.
        repeat (3) cyc(1, 13'h0001);
        check("t3_errs", 32'(err_count), 32'd4);
        check("t3_locked", 32'(locked), 32'd0);

        // 4: zeros ignored in search, mid-verify reseed, no lock, no errors.
        cyc(1, 13'h0000);
        cyc(1, 13'h0000);
        cyc(1, 13'h000F);
        cyc(1, 13'h001F);
        cyc(1, 13'h0AAA);
        check("t4_reseed", 32'(expected), 32'h1555);
        cyc(1, 13'h003F);
        check("t4_locked", 32'(locked), 32'd0);
        check("t4_errs", 32'(err_count), 32'd4);

        // 5: relock, reach 5 errors, then clear coincident with an error, then clear alone.
        g = 13'h007F;
        repeat (4) begin cyc(1, g); g = ref_next(g); end
        check("t5_relock", 32'(locked), 32'd1);
        cyc(1, 13'h0000); g = ref_next(g);
        cyc(1, g); g = ref_next(g);
        check("t5_errs5", 32'(err_count), 32'd5);
        cyc(1, 13'h0000, 1); g = ref_next(g);
        check("t5_clr_err", 32'(err_count), 32'd1);
        cyc(0, 13'h0000, 1);
        check("t5_clr", 32'(err_count), 32'd0);

        // Saturation: keep lock with two misses per match and overflow the counter.
        repeat (20) begin
            cyc(1, g); g = ref_next(g);
            cyc(1, g ^ 13'h0001); g = ref_next(g);
            cyc(1, g ^ 13'h0100); g = ref_next(g);
        end
        check("sat_count", 32'(err_count), ERR_MAX);
        check("sat_pulse", 32'(err_pulse), 32'd1);
        check("sat_locked", 32'(locked), 32'd1);

        // 6: reset in mid-verify with valid data present.
        cyc(0, '0, 0, 1);
        g = 13'h000F;
        repeat (3) begin cyc(1, g); g = ref_next(g); end
        cyc(1, g, 1, 1);
        check("t6_locked", 32'(locked), 32'd0);
        check("t6_expected", 32'(expected), 32'd0);
        check("t6_errs", 32'(err_count), 32'd0);

        // Randomized stream: gaps, zeros, corrupt and dropped words, stray clears and resets.
        g = W'($urandom_range(1, (1 << W) - 1));
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10)
                cyc(0, W'($urandom), $urandom_range(0, 29) == 0);
            else if (r < 13)
                cyc(1, 13'h0000, $urandom_range(0, 29) == 0);
            else if (r < 20) begin
                cyc(1, W'($urandom), $urandom_range(0, 29) == 0); g = ref_next(g);
            end else if (r < 23) begin
                g = ref_next(g); cyc(1, g); g = ref_next(g);
            end else if (r == 23)
                cyc(1, g, 0, 1);
            else begin
                cyc(1, g, $urandom_range(0, 29) == 0); g = ref_next(g);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
Receive-side companion to the team's 13-bit Fibonacci LFSR random generator (taps 12,3,2,0; shift left, feedback into bit 0). It accepts a stream of 13-bit generator words and self-synchronises to the sequence. Once locked, it predicts each next word, flags mismatches and counts errors. It sits downstream of any path carrying generator output (game logic, link test) to prove the sequence arrives intact and in order.

Parameters:
WIDTH, 13, LFSR word width; fixed to the generator width.
TAP_MASK, 13'h100D, feedback taps (bits 12,3,2,0); feedback = XOR-reduce(word & TAP_MASK).
LOCK_CNT, 4, consecutive correct predictions needed in VERIFY to declare lock; range 1..15.
LOSS_CNT, 3, consecutive mismatches in LOCKED that drop lock; range 1..15.
ERR_W, 16, error counter width.

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high; clears all state
in_valid  in  1  in_data is valid this cycle
in_data  in  WIDTH  received LFSR word
err_clr  in  1  synchronous clear of err_count
locked  out  1  high while in LOCKED state
err_pulse  out  1  one-cycle pulse per mismatch seen in LOCKED
err_count  out  ERR_W  saturating mismatch count
expected  out  WIDTH  current predicted next word (debug)

Behaviour:
- next(w) = {w[WIDTH-2:0], ^(w & TAP_MASK)}. Example: next(13'h000F) = 13'h001F.
- Reset values: state=SEARCH, locked=0, err_pulse=0, err_count=0, expected=0, match_cnt=0, miss_cnt=0.
- All outputs are registered, with a 1-cycle latency from the sampling edge. Cycles with in_valid=0 change nothing, except that err_pulse returns to 0 and err_clr still acts.
- SEARCH:
  - valid word == 0 (illegal LFSR state): ignored, stay in SEARCH.
  - valid nonzero word: expected <= next(word), match_cnt <= 0, go to VERIFY.
- VERIFY:
  - valid word == expected: match_cnt++, expected <= next(word). When the incremented match_cnt == LOCK_CNT, go to LOCKED and clear miss_cnt.
  - valid word != expected: reseed. If word != 0: expected <= next(word), match_cnt <= 0, stay in VERIFY. If word == 0: go to SEARCH.
  - Errors are never counted in VERIFY.
- LOCKED (flywheel mode, never reseeds from data):
  - match: expected <= next(expected), miss_cnt <= 0.
  - mismatch: expected <= next(expected), err_pulse <= 1, err_count increments (saturating at all-ones), miss_cnt++.
  - When the incremented miss_cnt == LOSS_CNT, go to SEARCH; locked falls on the same edge.
- locked = (state == LOCKED), registered.
- err_clr with a simultaneous counted error: the clear has priority for the old value, and the new error is still counted, so err_count = 1. err_clr alone: err_count = 0.
- err_count holds at 2^ERR_W-1 on further errors, but err_pulse still fires.
- Reset asserted mid-stream returns every register to its reset value on that edge, regardless of in_valid or err_clr.

Decomposition:
- Shared package lfsr_pkg holds: WIDTH, TAP_MASK, the state encoding (SEARCH=2'd0, VERIFY=2'd1, LOCKED=2'd2; 2'd3 recovers to SEARCH), and the next() function. The generator should be moved onto the same package.
- One combinational sub-module, lfsr_step (in: word; out: next word), is instantiated twice: once on in_data, once on expected.

Test Plan:
1. Reset, then feed 000F,001F,003F,007F,00FF on consecutive valid cycles -> locked=1 one cycle after the 00FF edge; expected=01FF; err_count=0.
2. Locked (after test 1), feed 01FF, then 1234 in place of 03FF, then 07FF -> single err_pulse after 1234; err_count=1; locked stays 1; expected tracks 0FFF after 07FF.
3. Locked, feed 3 consecutive wrong words (0001,0001,0001) -> err_count +3, three err_pulses, locked=0 after the third; state SEARCH.
4. In SEARCH, feed 0000,0000, then 000F,001F,0AAA,003F -> zeros ignored; 0AAA reseeds VERIFY (expected=next(0AAA)=1555); 003F is then a mismatch -> no lock, err_count unchanged.
5. Locked with err_count=5, assert err_clr on the same cycle as a mismatch -> err_count=1; next cycle err_clr alone -> err_count=0.
6. Mid-VERIFY (match_cnt=2), assert reset with in_valid=1 -> next cycle all outputs at reset values; locked=0, expected=0000.
